// File: rtl/univ_shift_ctrl.sv
// Command sequencer driving one univ_shift_reg: load, clear, logical shift and rotate by N.
// Define UNIV_SHIFT_ARITH_EN to make opcode 111 an arithmetic shift right (otherwise a NOP).
module univ_shift_ctrl #(
    parameter int unsigned C_NUM_BITS = 24,
    parameter int unsigned C_AMT_W    = 5
) (
    input  logic                  CK,
    input  logic                  RN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [C_AMT_W-1:0]    cmd_amt,
    input  logic                  cmd_fill,
    input  logic [C_NUM_BITS-1:0] cmd_data,
    input  logic [C_NUM_BITS-1:0] sr_q,
    output logic                  sr_s0,
    output logic                  sr_s1,
    output logic                  sr_sli,
    output logic                  sr_sri,
    output logic [C_NUM_BITS-1:0] sr_d,
    output logic                  busy,
    output logic                  done
);

    localparam logic [2:0] OpNop   = 3'b000;
    localparam logic [2:0] OpLoad  = 3'b001;
    localparam logic [2:0] OpShl   = 3'b010;
    localparam logic [2:0] OpShr   = 3'b011;
    localparam logic [2:0] OpRol   = 3'b100;
    localparam logic [2:0] OpRor   = 3'b101;
    localparam logic [2:0] OpClear = 3'b110;
    localparam logic [2:0] OpExt   = 3'b111;

    localparam logic [C_AMT_W-1:0] AmtOne = C_AMT_W'(1);
    localparam int unsigned Msb = C_NUM_BITS - 1;

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    state_e                state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic                  fill_q, fill_d;
    logic [C_NUM_BITS-1:0] data_q, data_d;
    logic [C_AMT_W-1:0]    cnt_q, cnt_d;
    logic                  cmd_is_shift;

    always_comb begin
        cmd_is_shift = 1'b0;
        case (cmd_op)
            OpShl, OpShr, OpRol, OpRor: cmd_is_shift = 1'b1;
`ifdef UNIV_SHIFT_ARITH_EN
            OpExt:                      cmd_is_shift = 1'b1;
`endif
            default:                    cmd_is_shift = 1'b0;
        endcase
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= StIdle;
            op_q    <= OpNop;
            fill_q  <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        fill_d    = fill_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        cmd_ready = 1'b0;
        sr_s0     = 1'b0;
        sr_s1     = 1'b0;
        sr_sli    = 1'b0;
        sr_sri    = 1'b0;
        sr_d      = '0;
        done      = 1'b0;

        case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    fill_d = cmd_fill;
                    data_d = cmd_data;
                    cnt_d  = cmd_amt;
                    if (cmd_op == OpLoad || cmd_op == OpClear) begin
                        state_d = StLoad;
                    end else if (cmd_is_shift && cmd_amt != '0) begin
                        state_d = StShift;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StLoad: begin
                sr_s0   = 1'b1;
                sr_s1   = 1'b1;
                sr_d    = (op_q == OpLoad) ? data_q : '0;
                state_d = StDone;
            end
            StShift: begin
                cnt_d = cnt_q - AmtOne;
                if (cnt_q == AmtOne) begin
                    state_d = StDone;
                end
                // Rotate/sign feedback comes straight from the live register output.
                case (op_q)
                    OpShl: begin sr_s1 = 1'b1; sr_sli = fill_q;    end
                    OpRol: begin sr_s1 = 1'b1; sr_sli = sr_q[Msb]; end
                    OpShr: begin sr_s0 = 1'b1; sr_sri = fill_q;    end
                    OpRor: begin sr_s0 = 1'b1; sr_sri = sr_q[0];   end
`ifdef UNIV_SHIFT_ARITH_EN
                    OpExt: begin sr_s0 = 1'b1; sr_sri = sr_q[Msb]; end
`endif
                    default: ;
                endcase
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy = ~cmd_ready;

endmodule
